// File: rtl/zii_ac_pkg.sv
// Shared constants, state encodings and helpers for the
// Zorro II AutoConfig host (E8xxxx enumeration).
package zii_ac_pkg;

    localparam logic [7:0] AC_E8_BASE = 8'hE8;

    localparam logic [5:0] IDX_TYPE    = 6'h00;
    localparam logic [5:0] IDX_SIZE    = 6'h01;
    localparam logic [5:0] IDX_PROD    = 6'h02;
    localparam logic [5:0] IDX_MFG     = 6'h08;
    localparam logic [5:0] IDX_ROMVEC  = 6'h14;
    localparam logic [5:0] IDX_BASE_HI = 6'h24;
    localparam logic [5:0] IDX_BASE_LO = 6'h25;
    localparam logic [5:0] IDX_SHUTUP  = 6'h26;

    localparam logic [8:0] SPACE_LO = 9'h020;
    localparam logic [8:0] SPACE_HI = 9'h0A0;

    typedef enum logic [1:0] {
        B_IDLE,
        B_ADDR,
        B_STRB,
        B_REL
    } bus_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ROM,
        S_DECIDE,
        S_WR_LO,
        S_WR_HI,
        S_SHUTUP,
        S_REPORT,
        S_FIN
    } ac_state_e;

    // Board size in 64 KB units from er_type[2:0].
    function automatic logic [8:0] size_units(input logic [2:0] code);
        logic [8:0] u;
        unique case (code)
            3'd0: u = 9'd128;
            3'd1: u = 9'd1;
            3'd2: u = 9'd2;
            3'd3: u = 9'd4;
            3'd4: u = 9'd8;
            3'd5: u = 9'd16;
            3'd6: u = 9'd32;
            3'd7: u = 9'd64;
        endcase
        return u;
    endfunction

    // ROM read sequence: 00-03 type/prod, 08-0B mfg, 14-17 rom vector.
    function automatic logic [5:0] rom_idx(input logic [3:0] step);
        logic [5:0] idx;
        unique case (step[3:2])
            2'd0:    idx = IDX_TYPE | {4'b0, step[1:0]};
            2'd1:    idx = IDX_MFG | {4'b0, step[1:0]};
            2'd2:    idx = IDX_ROMVEC | {4'b0, step[1:0]};
            default: idx = IDX_TYPE;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/zii_bus_cycle.sv
// Single Zorro II bus access into $E8xxxx: ADDR -> STRB -> REL,
// started by req_i in idle and finished by a 1-clk ack_o.
module zii_bus_cycle
    import zii_ac_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int IDLE_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [5:0]  idx_i,
    input  logic [3:0]  wdata_i,
    input  logic [3:0]  d_i,
    output logic        ack_o,
    output logic [3:0]  rdata_o,
    output logic        as_n_o,
    output logic        ds_n_o,
    output logic        rw_n_o,
    output logic [23:1] a_o,
    output logic [3:0]  d_o,
    output logic        d_oe_o
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);

    bus_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] idx_q, idx_d;
    logic       we_q, we_d;
    logic [3:0] wdata_q, wdata_d;
    logic [3:0] rdata_q, rdata_d;
    logic       active;

    // Access state and latched request; reset drops the bus at once.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= B_IDLE;
            cnt_q   <= 8'h0;
            idx_q   <= 6'h0;
            we_q    <= 1'b0;
            wdata_q <= 4'h0;
            rdata_q <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Access sequencing; read data captured on the last strobe clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_o   = 1'b0;
        unique case (state_q)
            B_IDLE: begin
                if (req_i) begin
                    idx_d   = idx_i;
                    we_d    = we_i;
                    wdata_d = wdata_i;
                    state_d = B_ADDR;
                end
            end
            B_ADDR: begin
                cnt_d   = 8'h0;
                state_d = B_STRB;
            end
            B_STRB: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 8'h0;
                    state_d = B_REL;
                    if (!we_q) rdata_d = d_i;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            B_REL: begin
                if (cnt_q == IDLE_LAST) begin
                    ack_o   = 1'b1;
                    state_d = B_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    assign active  = (state_q != B_IDLE);
    assign as_n_o  = (state_q != B_STRB);
    assign ds_n_o  = (state_q != B_STRB);
    assign rw_n_o  = !(active && we_q);
    assign d_oe_o  = active && we_q;
    assign d_o     = d_oe_o ? wdata_q : 4'h0;
    assign a_o     = active ? {AC_E8_BASE, 9'h000, idx_q} : 23'h0;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/autoconfig_zii_host.sv
// Zorro II AutoConfig enumerator: reads each board ROM and assigns
// a base or shuts it up. Option macro: AC_ROMVEC_EN.
module autoconfig_zii_host
    import zii_ac_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int IDLE_CYCLES = 1,
    parameter int MAX_BOARDS  = 8
) (
    input  logic         C7M,
    input  logic         RESET_n,
    input  logic         START,
    output logic         BUSY,
    output logic         DONE,
    output logic         OVERFLOW,
    output logic [3:0]   BOARD_COUNT,
    output logic         AS_n,
    output logic         DS_n,
    output logic         RW_n,
    output logic [23:1]  A_OUT,
    output logic [15:12] D_OUT,
    output logic         D_OE,
    input  logic [15:12] D_IN,
    output logic         REC_VALID,
    output logic [15:0]  REC_MFG,
    output logic [7:0]   REC_PROD,
    output logic [7:0]   REC_TYPE,
    output logic [7:0]   REC_BASE,
    output logic         REC_SHUTUP
`ifdef AC_ROMVEC_EN
    ,
    output logic [15:0]  REC_ROMVEC
`endif
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BOARDS);

    ac_state_e  state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] type_q, type_d;
    logic [7:0] prod_q, prod_d;
    logic [15:0] mfg_q, mfg_d;
    logic [7:0] base_q, base_d;
    logic       shut_q, shut_d;
    logic [8:0] ptr_q, ptr_d;
    logic [3:0] count_q, count_d;
    logic       done_q, done_d;
    logic       ovf_q, ovf_d;
    logic       rv_q, rv_d;
    logic [15:0] rmfg_q, rmfg_d;
    logic [7:0] rprod_q, rprod_d;
    logic [7:0] rtype_q, rtype_d;
    logic [7:0] rbase_q, rbase_d;
    logic       rshut_q, rshut_d;
`ifdef AC_ROMVEC_EN
    logic [15:0] romvec_q, romvec_d;
    logic [15:0] rromvec_q, rromvec_d;
`endif

    logic       req, we, ack, rv_more;
    logic [5:0] idx;
    logic [3:0] wdata, rdata;
    logic [8:0] size_w, off_w, aligned_w, end_w;

    zii_bus_cycle #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .IDLE_CYCLES(IDLE_CYCLES)
    ) u_bus (
        .clk_i  (C7M),
        .rst_ni (RESET_n),
        .req_i  (req),
        .we_i   (we),
        .idx_i  (idx),
        .wdata_i(wdata),
        .d_i    (D_IN),
        .ack_o  (ack),
        .rdata_o(rdata),
        .as_n_o (AS_n),
        .ds_n_o (DS_n),
        .rw_n_o (RW_n),
        .a_o    (A_OUT),
        .d_o    (D_OUT),
        .d_oe_o (D_OE)
    );

`ifdef AC_ROMVEC_EN
    assign rv_more = type_q[4];
`else
    assign rv_more = 1'b0;
`endif

    // Alignment is counted from the start of the space, so large
    // boards still land at $200000.
    assign size_w    = size_units(type_q[2:0]);
    assign off_w     = ptr_q - SPACE_LO;
    assign aligned_w = ((off_w + size_w - 9'd1) & ~(size_w - 9'd1)) + SPACE_LO;
    assign end_w     = aligned_w + size_w;

    // Enumeration state, allocator and report registers.
    always_ff @(posedge C7M) begin
        if (!RESET_n) begin
            state_q <= S_IDLE;
            step_q  <= 4'h0;
            type_q  <= 8'h0;
            prod_q  <= 8'h0;
            mfg_q   <= 16'h0;
            base_q  <= 8'h0;
            shut_q  <= 1'b0;
            ptr_q   <= SPACE_LO;
            count_q <= 4'h0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
            rmfg_q  <= 16'h0;
            rprod_q <= 8'h0;
            rtype_q <= 8'h0;
            rbase_q <= 8'h0;
            rshut_q <= 1'b0;
`ifdef AC_ROMVEC_EN
            romvec_q  <= 16'h0;
            rromvec_q <= 16'h0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            type_q  <= type_d;
            prod_q  <= prod_d;
            mfg_q   <= mfg_d;
            base_q  <= base_d;
            shut_q  <= shut_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            rv_q    <= rv_d;
            rmfg_q  <= rmfg_d;
            rprod_q <= rprod_d;
            rtype_q <= rtype_d;
            rbase_q <= rbase_d;
            rshut_q <= rshut_d;
`ifdef AC_ROMVEC_EN
            romvec_q  <= romvec_d;
            rromvec_q <= rromvec_d;
`endif
        end
    end

    // Enumeration next-state, bus requests and allocation decisions.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        type_d  = type_q;
        prod_d  = prod_q;
        mfg_d   = mfg_q;
        base_d  = base_q;
        shut_d  = shut_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        rv_d    = 1'b0;
        rmfg_d  = rmfg_q;
        rprod_d = rprod_q;
        rtype_d = rtype_q;
        rbase_d = rbase_q;
        rshut_d = rshut_q;
`ifdef AC_ROMVEC_EN
        romvec_d  = romvec_q;
        rromvec_d = rromvec_q;
`endif
        req   = 1'b0;
        we    = 1'b0;
        idx   = rom_idx(step_q);
        wdata = 4'h0;
        unique case (state_q)
            S_IDLE: begin
                if (START && !done_q) begin
                    state_d = S_RD_ROM;
                    step_d  = 4'h0;
                    ptr_d   = SPACE_LO;
                    count_d = 4'h0;
                    ovf_d   = 1'b0;
`ifdef AC_ROMVEC_EN
                    romvec_d = 16'h0;
`endif
                end
            end
            S_RD_ROM: begin
                req = 1'b1;
                if (ack) begin
                    if (step_q[3]) begin
`ifdef AC_ROMVEC_EN
                        romvec_d = {romvec_q[11:0], ~rdata};
`endif
                    end else if (step_q[2]) begin
                        mfg_d = {mfg_q[11:0], ~rdata};
                    end else if (step_q[1]) begin
                        prod_d = {prod_q[3:0], ~rdata};
                    end else begin
                        type_d = {type_q[3:0], rdata};
                    end
                    // All-ones type: nobody is driving the bus.
                    if (step_q == 4'd1 && type_q[3:0] == 4'hF
                        && rdata == 4'hF) begin
                        state_d = S_FIN;
                    end else if ((step_q == 4'd7 && !rv_more)
                                 || step_q == 4'd11) begin
                        state_d = S_DECIDE;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            S_DECIDE: begin
                if (mfg_q == 16'h0) begin
                    state_d = S_FIN;
                end else if (type_q[7:6] != 2'b11 || end_w > SPACE_HI) begin
                    base_d  = 8'h0;
                    shut_d  = 1'b1;
                    state_d = S_SHUTUP;
                end else begin
                    base_d  = aligned_w[7:0];
                    shut_d  = 1'b0;
                    ptr_d   = end_w;
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: begin
                req   = 1'b1;
                we    = 1'b1;
                idx   = IDX_BASE_LO;
                wdata = base_q[3:0];
                if (ack) state_d = S_WR_HI;
            end
            S_WR_HI: begin
                req   = 1'b1;
                we    = 1'b1;
                idx   = IDX_BASE_HI;
                wdata = base_q[7:4];
                if (ack) state_d = S_REPORT;
            end
            S_SHUTUP: begin
                req   = 1'b1;
                we    = 1'b1;
                idx   = IDX_SHUTUP;
                if (ack) state_d = S_REPORT;
            end
            S_REPORT: begin
                rv_d    = 1'b1;
                rmfg_d  = mfg_q;
                rprod_d = prod_q;
                rtype_d = type_q;
                rbase_d = base_q;
                rshut_d = shut_q;
`ifdef AC_ROMVEC_EN
                rromvec_d = romvec_q;
                romvec_d  = 16'h0;
`endif
                count_d = count_q + 4'd1;
                step_d  = 4'h0;
                state_d = (count_d == MAX_CNT) ? S_FIN : S_RD_ROM;
            end
            S_FIN: begin
                done_d  = 1'b1;
                ovf_d   = (count_q == MAX_CNT);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY        = (state_q != S_IDLE);
    assign DONE        = done_q;
    assign OVERFLOW    = ovf_q;
    assign BOARD_COUNT = count_q;
    assign REC_VALID   = rv_q;
    assign REC_MFG     = rmfg_q;
    assign REC_PROD    = rprod_q;
    assign REC_TYPE    = rtype_q;
    assign REC_BASE    = rbase_q;
    assign REC_SHUTUP  = rshut_q;
`ifdef AC_ROMVEC_EN
    assign REC_ROMVEC  = rromvec_q;
`endif

endmodule
